// File: rtl/sdram_burst_reader.sv
// Splits one read request of arbitrary length into Avalon-MM bursts of at most
// MAX_BURST beats and returns the data as an indexed, in-order beat stream.
module sdram_burst_reader #(
    parameter int SDRAM_W   = 128,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        read_addr,
    input  logic [CNT_W-1:0]   read_cnt,
    input  logic               read_start,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    output logic [CNT_W-1:0]   out_idx,
    output logic [SDRAM_W-1:0] out_data,
    output logic [31:0]        address,
    output logic [10:0]        burstcount,
    output logic               read,
    input  logic               waitrequest,
    input  logic [SDRAM_W-1:0] readdata,
    input  logic               readdatavalid
);

    localparam int BYTES = SDRAM_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   iss_rem_r, iss_rem_s;
    logic [CNT_W-1:0]   rcv_cnt_r, rcv_cnt_s;
    logic [CNT_W-1:0]   total_r, total_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               out_valid_r, out_valid_s;
    logic [CNT_W-1:0]   out_idx_r, out_idx_s;
    logic [SDRAM_W-1:0] out_data_r, out_data_s;
    logic [31:0]        address_r, address_s;
    logic [10:0]        burstcount_r, burstcount_s;
    logic               read_r, read_s;
    logic               accept_s;
    logic [CNT_W-1:0]   rem_left_s;

    // Length of the next burst: whatever is left, capped at MAX_BURST.
    function automatic logic [10:0] burst_len(input logic [CNT_W-1:0] rem);
        if (32'(rem) > 32'(MAX_BURST)) begin
            burst_len = 11'(MAX_BURST);
        end else begin
            burst_len = 11'(rem);
        end
    endfunction

    assign accept_s   = read_r && !waitrequest;
    assign rem_left_s = iss_rem_r - CNT_W'(burstcount_r);

    // Next-state and next-output computation for the issue/return engine.
    always_comb begin
        state_s      = state_r;
        iss_rem_s    = iss_rem_r;
        rcv_cnt_s    = rcv_cnt_r;
        total_s      = total_r;
        done_s       = 1'b0;
        out_valid_s  = 1'b0;
        out_idx_s    = out_idx_r;
        out_data_s   = out_data_r;
        address_s    = address_r;
        burstcount_s = burstcount_r;
        read_s       = read_r;

        case (state_r)
            IDLE: begin
                if (read_start) begin
                    if (read_cnt == '0) begin
                        done_s = 1'b1;
                    end else begin
                        state_s      = ISSUE;
                        total_s      = read_cnt;
                        iss_rem_s    = read_cnt;
                        rcv_cnt_s    = '0;
                        read_s       = 1'b1;
                        address_s    = read_addr;
                        burstcount_s = burst_len(read_cnt);
                    end
                end else begin
                    read_s = 1'b0;
                end
            end
            ISSUE: begin
                // Next burst goes out the cycle after acceptance, no bubble.
                if (accept_s) begin
                    iss_rem_s = rem_left_s;
                    address_s = address_r + 32'(burstcount_r) * 32'(BYTES);
                    if (rem_left_s == '0) begin
                        read_s  = 1'b0;
                        state_s = DRAIN;
                    end else begin
                        burstcount_s = burst_len(rem_left_s);
                    end
                end else begin
                    read_s = read_r;
                end
            end
            DRAIN: begin
                read_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                read_s  = 1'b0;
            end
        endcase

        // Returned beats are only meaningful while a request is open.
        if ((state_r != IDLE) && readdatavalid) begin
            out_valid_s = 1'b1;
            out_idx_s   = rcv_cnt_r;
            out_data_s  = readdata;
            rcv_cnt_s   = rcv_cnt_r + CNT_W'(1);
            if (rcv_cnt_r == total_r - CNT_W'(1)) begin
                done_s  = 1'b1;
                state_s = IDLE;
                read_s  = 1'b0;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            out_valid_s = 1'b0;
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            iss_rem_r    <= '0;
            rcv_cnt_r    <= '0;
            total_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_idx_r    <= '0;
            out_data_r   <= '0;
            address_r    <= 32'd0;
            burstcount_r <= 11'd0;
            read_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            iss_rem_r    <= iss_rem_s;
            rcv_cnt_r    <= rcv_cnt_s;
            total_r      <= total_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            out_valid_r  <= out_valid_s;
            out_idx_r    <= out_idx_s;
            out_data_r   <= out_data_s;
            address_r    <= address_s;
            burstcount_r <= burstcount_s;
            read_r       <= read_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign out_valid  = out_valid_r;
    assign out_idx    = out_idx_r;
    assign out_data   = out_data_r;
    assign address    = address_r;
    assign burstcount = burstcount_r;
    assign read       = read_r;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader: an Avalon slave model returns a
// per-address data pattern; beats, commands and done pulses are checked.
module tb_sdram_burst_reader;

    localparam int SDRAM_W   = 128;
    localparam int CNT_W     = 16;
    localparam int MAX_BURST = 64;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [31:0]        read_addr = 32'd0;
    logic [CNT_W-1:0]   read_cnt = '0;
    logic               read_start = 1'b0;
    logic               busy, done, out_valid, read;
    logic [CNT_W-1:0]   out_idx;
    logic [SDRAM_W-1:0] out_data;
    logic [31:0]        address;
    logic [10:0]        burstcount;
    logic               waitrequest = 1'b0;
    logic [SDRAM_W-1:0] readdata = '0;
    logic               readdatavalid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] base;
        int          cnt;
    } req_t;

    req_t        req_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] cmd_addr_q[$];
    logic [10:0] cmd_bc_q[$];
    int          cmd_cyc_q[$];
    int          cyc = 0;
    int          beat_n = 0;
    int          done_cnt = 0;
    int          gap = 0;
    int          stall_at = 0;
    int          stall_left = 0;
    logic [31:0] stall_exp_addr = 32'd0;

    sdram_burst_reader #(
        .SDRAM_W(SDRAM_W), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .read_addr(read_addr), .read_cnt(read_cnt), .read_start(read_start),
        .busy(busy), .done(done), .out_valid(out_valid), .out_idx(out_idx),
        .out_data(out_data), .address(address), .burstcount(burstcount),
        .read(read), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1234_5678, a};
    endfunction

    // Slave: log accepted commands and queue one beat address per burst beat.
    always @(posedge clk) begin
        if (rst_n && read && !waitrequest) begin
            cmd_addr_q.push_back(address);
            cmd_bc_q.push_back(burstcount);
            cmd_cyc_q.push_back(cyc);
            for (int i = 0; i < int'(burstcount); i++)
                beat_q.push_back(address + 32'(i) * 32'd16);
        end
        cyc++;
    end

    // Slave: stall injection and in-order data return.
    always @(negedge clk) begin
        if (stall_left > 0 && cmd_addr_q.size() == stall_at) begin
            waitrequest = 1'b1;
            stall_left--;
            check_eq("stall_read", read, 1);
            check_eq("stall_addr", address, stall_exp_addr);
            check_eq("stall_bc", burstcount, 64);
        end else begin
            waitrequest = 1'b0;
        end
        if (beat_q.size() > 0 && (cyc % (gap + 1)) == 0) begin
            readdatavalid = 1'b1;
            readdata = pat(beat_q.pop_front());
        end else begin
            readdatavalid = 1'b0;
        end
    end

    // Output stream monitor against the queue of accepted requests.
    always @(negedge clk) begin
        if (rst_n && (out_valid || done)) begin
            if (req_q.size() == 0) begin
                check_eq("stray_valid", out_valid, 0);
                check_eq("stray_done", done, 0);
            end else if (out_valid) begin
                check_eq("beat_idx", out_idx, beat_n);
                check_eq("beat_data", out_data, pat(req_q[0].base + 32'(beat_n) * 32'd16));
                check_eq("done_on_last", done, (beat_n == req_q[0].cnt - 1));
                beat_n++;
                if (beat_n == req_q[0].cnt) begin
                    check_eq("busy_at_done", busy, 0);
                    done_cnt++;
                    beat_n = 0;
                    void'(req_q.pop_front());
                end
            end else begin
                check_eq("done_no_beat_cnt", req_q[0].cnt, 0);
                done_cnt++;
                void'(req_q.pop_front());
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input int c, input bit track);
        req_t r;
        read_addr  = a;
        read_cnt   = CNT_W'(c);
        read_start = 1'b1;
        if (track) begin
            r.base = a;
            r.cnt  = c;
            req_q.push_back(r);
        end
        @(negedge clk);
        read_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, (n < 2000), 1);
    endtask

    task automatic clear_log();
        cmd_addr_q.delete();
        cmd_bc_q.delete();
        cmd_cyc_q.delete();
    endtask

    task automatic check_cmd(input string tag, input int i, input logic [31:0] a, input int bc);
        if (cmd_addr_q.size() > i) begin
            check_eq({tag, "_addr"}, cmd_addr_q[i], a);
            check_eq({tag, "_bc"}, cmd_bc_q[i], bc);
        end else begin
            check_eq({tag, "_present"}, 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_read", read, 0);
        check_eq("rst_out_idx", out_idx, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_address", address, 0);
        check_eq("rst_burstcount", burstcount, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single burst.
        clear_log();
        start_req(32'h1000, 4, 1'b1);
        check_eq("single_read_n1", read, 1);
        check_eq("single_busy_n1", busy, 1);
        check_eq("single_addr_n1", address, 32'h1000);
        check_eq("single_bc_n1", burstcount, 4);
        wait_done("single");
        @(negedge clk);
        check_eq("single_done_pulse", done, 0);
        check_eq("single_ncmd", cmd_addr_q.size(), 1);
        check_cmd("single_c0", 0, 32'h1000, 4);
        check_eq("single_done_cnt", done_cnt, 1);

        // Split request: 64 + 64 + 22 on consecutive cycles.
        clear_log();
        start_req(32'h0, 150, 1'b1);
        wait_done("split");
        @(negedge clk);
        check_eq("split_ncmd", cmd_addr_q.size(), 3);
        check_cmd("split_c0", 0, 32'h000, 64);
        check_cmd("split_c1", 1, 32'h400, 64);
        check_cmd("split_c2", 2, 32'h800, 22);
        if (cmd_cyc_q.size() == 3) begin
            check_eq("split_gap01", cmd_cyc_q[1] - cmd_cyc_q[0], 1);
            check_eq("split_gap12", cmd_cyc_q[2] - cmd_cyc_q[1], 1);
        end else begin
            check_eq("split_cyc_log", cmd_cyc_q.size(), 3);
        end
        check_eq("split_done_cnt", done_cnt, 2);

        // Stall the second burst for 3 cycles.
        clear_log();
        stall_at = 1;
        stall_left = 3;
        stall_exp_addr = 32'h2400;
        start_req(32'h2000, 150, 1'b1);
        wait_done("stall");
        @(negedge clk);
        check_eq("stall_all_applied", stall_left, 0);
        check_eq("stall_ncmd", cmd_addr_q.size(), 3);
        check_cmd("stall_c0", 0, 32'h2000, 64);
        check_cmd("stall_c1", 1, 32'h2400, 64);
        check_cmd("stall_c2", 2, 32'h2800, 22);
        if (cmd_cyc_q.size() == 3) begin
            check_eq("stall_gap01", cmd_cyc_q[1] - cmd_cyc_q[0], 4);
            check_eq("stall_gap12", cmd_cyc_q[2] - cmd_cyc_q[1], 1);
        end else begin
            check_eq("stall_cyc_log", cmd_cyc_q.size(), 3);
        end
        check_eq("stall_done_cnt", done_cnt, 3);

        // Zero count: done in N+1, no bus activity.
        clear_log();
        start_req(32'h5000, 0, 1'b1);
        check_eq("zero_done_n1", done, 1);
        check_eq("zero_read_n1", read, 0);
        check_eq("zero_busy_n1", busy, 0);
        @(negedge clk);
        check_eq("zero_done_n2", done, 0);
        check_eq("zero_read_n2", read, 0);
        check_eq("zero_busy_n2", busy, 0);
        check_eq("zero_ncmd", cmd_addr_q.size(), 0);
        check_eq("zero_done_cnt", done_cnt, 4);

        // Start while busy is ignored; start in the done cycle is taken.
        clear_log();
        start_req(32'h3000, 20, 1'b1);
        repeat (3) @(negedge clk);
        start_req(32'h9000, 5, 1'b0);
        wait_done("busy1");
        start_req(32'h4000, 3, 1'b1);
        check_eq("b2b_read", read, 1);
        check_eq("b2b_addr", address, 32'h4000);
        wait_done("busy2");
        @(negedge clk);
        check_eq("busy_ncmd", cmd_addr_q.size(), 2);
        check_cmd("busy_c0", 0, 32'h3000, 20);
        check_cmd("busy_c1", 1, 32'h4000, 3);
        check_eq("busy_done_cnt", done_cnt, 6);

        // Reset during DRAIN with beats still outstanding.
        gap = 3;
        start_req(32'h6000, 8, 1'b1);
        repeat (8) @(negedge clk);
        check_eq("rstm_in_drain_read", read, 0);
        check_eq("rstm_in_drain_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        req_q.delete();
        beat_n = 0;
        #1;
        check_eq("rstm_busy", busy, 0);
        check_eq("rstm_done", done, 0);
        check_eq("rstm_out_valid", out_valid, 0);
        check_eq("rstm_read", read, 0);
        check_eq("rstm_out_idx", out_idx, 0);
        check_eq("rstm_out_data", out_data, 0);
        check_eq("rstm_address", address, 0);
        check_eq("rstm_burstcount", burstcount, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("rstm_no_valid", out_valid, 0);
            check_eq("rstm_no_done", done, 0);
        end
        check_eq("rstm_stale_drained", beat_q.size(), 0);
        check_eq("rstm_done_cnt", done_cnt, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_reader.md
# sdram_burst_reader

Parametrised SDRAM read engine that turns one read request of arbitrary length into a sequence of Avalon-MM burst reads no longer than `MAX_BURST` beats each. It drives the SDRAM read master port and returns data to the requester as an indexed, in-order beat stream, with busy/done status. It sits between NPU load units (weights, activations) and the SDRAM controller, and replaces the hand-sequenced single-burst read path.

## Interface

**Parameters**
- `SDRAM_W`, 128: data beat width in bits; a multiple of 8. Bytes per beat: `BYTES = SDRAM_W/8`.
- `CNT_W`, 16: width of the total beat count and of the beat index.
- `MAX_BURST`, 64: maximum beats per Avalon burst; a power of two, 1..1024.

**Ports**
- `clk`, input, 1: clock. One clock domain; every signal below is synchronous to `clk`.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `read_addr`, input, 32: byte base address of the request; must be aligned to `BYTES`.
- `read_cnt`, input, CNT_W: total beats requested.
- `read_start`, input, 1: request strobe; sampled only in IDLE.
- `busy`, output, 1: a request is in progress.
- `done`, output, 1: one-cycle pulse when the request completes.
- `out_valid`, output, 1: `out_data` holds a valid beat.
- `out_idx`, output, CNT_W: beat index, 0 ≤ idx < `read_cnt`.
- `out_data`, output, SDRAM_W: beat data.
- `address`, output, 32: Avalon byte address.
- `burstcount`, output, 11: Avalon burst length.
- `read`, output, 1: Avalon read command.
- `waitrequest`, input, 1: Avalon stall.
- `readdata`, input, SDRAM_W: Avalon read data.
- `readdatavalid`, input, 1: Avalon data valid.

## Operation

- **Reset:** state goes to IDLE. `busy`, `done`, `out_valid`, `read` = 0. `out_idx`, `out_data`, `address`, `burstcount` = 0.
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - `read_start` with `read_cnt` = 0: pulse `done` on the next cycle, stay in IDLE, no bus activity.
  - `read_start` with `read_cnt` > 0: latch the request, then go to ISSUE. Internal state at this point: `iss_addr` = `read_addr`, `iss_rem` = `read_cnt`, `rcv_cnt` = 0.
- **ISSUE:**
  - Drive `read` = 1, `address` = `iss_addr`, `burstcount` = min(`iss_rem`, `MAX_BURST`).
  - While `waitrequest` = 1, hold `read`, `address` and `burstcount` stable.
  - A command is accepted when `read` && !`waitrequest`. On acceptance: `iss_addr` += `burstcount`·`BYTES` (32-bit wrap), and `iss_rem` -= `burstcount`.
  - If `iss_rem` becomes 0, go to DRAIN and drop `read`. Otherwise present the next burst on the next cycle; bursts are issued back-to-back with no dead cycle between them.
- **DRAIN:** wait for the remaining data beats.
- **Data return (ISSUE and DRAIN):**
  - Each `readdatavalid` registers `out_data` = `readdata`, `out_valid` = 1, `out_idx` = `rcv_cnt`, then increments `rcv_cnt`.
  - Data may arrive while later bursts are still being issued.
- **Completion:** the beat with `rcv_cnt` = `read_cnt`−1 also asserts `done` and returns the state to IDLE.
- **`busy`:** equals (state ≠ IDLE), registered.
- **Ignored inputs:**
  - `read_start` is ignored while `busy` = 1.
  - `readdatavalid` is ignored in IDLE, so stale beats after a reset are discarded.
- **Reset mid-request:** the request is abandoned immediately and no `done` pulse is produced.

## Timing

- All outputs are registered.
- `read_start` in cycle N → `read` = 1 and `busy` = 1 in cycle N+1.
- `readdatavalid` in cycle M → `out_valid`/`out_idx`/`out_data` in cycle M+1. The output stream has no backpressure.
- `done` is high in the same cycle as the final `out_valid`; `busy` is 0 in that cycle.
- A `read_start` in the `done` cycle is accepted.
- Beat throughput is one per cycle.
- The issue side sustains one accepted burst command per cycle.

## Test plan

- **Single burst:** `SDRAM_W`=128, `MAX_BURST`=64, `read_addr`=0x1000, `read_cnt`=4, `waitrequest`=0.
  - Expect one command: `address`=0x1000, `burstcount`=4.
  - Expect 4 beats with `out_idx` 0..3, and `done` together with `out_idx`=3.
- **Split request:** `read_addr`=0x0, `read_cnt`=150.
  - Expect bursts 64@0x000, 64@0x400, 22@0x800 on consecutive cycles.
  - Expect 150 beats in order and a single `done` pulse.
- **Stall:** hold `waitrequest`=1 for 3 cycles on the second burst.
  - `address` and `burstcount` stay stable throughout the stall.
  - Exactly 3 commands are accepted in total.
  - Data interleaved with issuing is still indexed correctly.
- **Zero count:** `read_cnt`=0.
  - `done` pulses in cycle N+1.
  - `read` stays 0 and `busy` stays 0.
- **Start while busy:** pulse `read_start` with new `read_addr`/`read_cnt` mid-request.
  - The new request is ignored and the original completes unchanged.
  - A back-to-back start in the `done` cycle is accepted.
- **Reset mid-request:** assert `rst_n`=0 during DRAIN.
  - All outputs go to 0 asynchronously.
  - Beats arriving after reset produce no `out_valid`, and no `done` is seen.
